// File: rtl/pol_sweep_pkg.sv
// Shared definitions for the polynomial sweep accumulator.
//   state_e      - FSM state encoding (3-bit)
//   ARG_* / OP_* - codes forwarded on mem_arg / mem_op
//   DEF_DATA_W   - default memory result width (sign-magnitude)
//   sm_to_tc()   - sign-magnitude result -> two's complement, DEF_ACC_W+1 bits
`timescale 1ns/1ps
package pol_sweep_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_ACC_W  = 13;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] ARG_P1 = 2'b00;
  localparam logic [1:0] ARG_P2 = 2'b01;
  localparam logic [1:0] ARG_M1 = 2'b10;
  localparam logic [1:0] ARG_M2 = 2'b11;

  localparam logic OP_POLY  = 1'b0;
  localparam logic OP_DERIV = 1'b1;

  // Negative zero needs no special case: negating a zero magnitude yields 0.
  function automatic logic signed [DEF_ACC_W:0] sm_to_tc(input logic [DEF_DATA_W-1:0] sm);
    logic signed [DEF_ACC_W:0] mag;
    mag = $signed({{(DEF_ACC_W + 2 - DEF_DATA_W){1'b0}}, sm[DEF_DATA_W-2:0]});
    return sm[DEF_DATA_W-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/pol_sweep_acc_sm_acc.sv
// pol_sm_acc: combinational sign-magnitude conversion plus saturating add.
//   data_i  - memory result, sign-magnitude
//   sum_i   - current accumulator (two's complement, ACC_W bits)
//   sum_o   - next accumulator value, saturated to the ACC_W range
//   ovf_o   - high when this addition saturated
`timescale 1ns/1ps
module pol_sm_acc
  import pol_sweep_pkg::*;
#(
  parameter int ACC_W  = 13,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [ACC_W-1:0]  sum_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic signed [DEF_ACC_W:0] tc_full;
  logic signed [ACC_W:0]     val;
  logic        [ACC_W:0]     wide;

  assign tc_full = sm_to_tc(data_i);
  assign val     = (ACC_W+1)'(tc_full);
  // One guard bit: the two top bits disagree exactly when the true sum
  // has left the ACC_W range.
  assign wide    = {sum_i[ACC_W-1], sum_i} + val;

  always_comb begin
    ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
    sum_o = wide[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pol_sweep_acc.sv
// pol_sweep_acc: sequences the polynomial memory over an address range
// (WRITE -> READ -> CAPTURE per entry) and accumulates the results.
//   CLK, RSTn            - clock, async active-low reset
//   start                - sweep request, sampled in IDLE only
//   op_in, arg_in        - latched at start, forwarded on mem_op / mem_arg
//   first_addr/last_addr - inclusive range, wraps 15 -> 0
//   mem_mode/addr/op/arg - memory control (mem_mode=1 evaluates+stores)
//   mem_data             - sign-magnitude read result
//   busy, done           - handshake; sum/count/ovf - sweep results
// Optional: define POL_SWEEP_PEAK_EN for peak_max/peak_min and their
// addresses (sign-magnitude values, earliest address kept on ties).
`timescale 1ns/1ps
module pol_sweep_acc
  import pol_sweep_pkg::*;
#(
  parameter int ACC_W  = 13,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              op_in,
  input  logic [1:0]        arg_in,
  input  logic [3:0]        first_addr,
  input  logic [3:0]        last_addr,
  output logic              mem_mode,
  output logic [3:0]        mem_addr,
  output logic              mem_op,
  output logic [1:0]        mem_arg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum,
  output logic [4:0]        count,
  output logic              ovf
`ifdef POL_SWEEP_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [3:0]        peak_max_addr,
  output logic [3:0]        peak_min_addr
`endif
);

  state_e             state_q, state_d;
  logic [3:0]         addr_q, addr_d;
  logic               op_q, op_d;
  logic [1:0]         arg_q, arg_d;
  logic [4:0]         n_q, n_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [4:0]         count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   acc_sum;
  logic               acc_ovf;

`ifdef POL_SWEEP_PEAK_EN
  logic [DATA_W-1:0]  pmax_q, pmax_d, pmin_q, pmin_d;
  logic [3:0]         pmax_addr_q, pmax_addr_d, pmin_addr_q, pmin_addr_d;
  logic signed [DEF_ACC_W:0] cur_tc, max_tc, min_tc;

  assign cur_tc = sm_to_tc(mem_data);
  assign max_tc = sm_to_tc(pmax_q);
  assign min_tc = sm_to_tc(pmin_q);
`endif

  pol_sm_acc #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_acc (
    .data_i (mem_data),
    .sum_i  (sum_q),
    .sum_o  (acc_sum),
    .ovf_o  (acc_ovf)
  );

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    arg_d   = arg_q;
    n_d     = n_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef POL_SWEEP_PEAK_EN
    pmax_d      = pmax_q;
    pmin_d      = pmin_q;
    pmax_addr_d = pmax_addr_q;
    pmin_addr_d = pmin_addr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_in;
          arg_d   = arg_in;
          addr_d  = first_addr;
          // The 4-bit difference wraps mod 16, giving the wrapped length.
          n_d     = {1'b0, 4'(last_addr - first_addr)} + 5'd1;
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE:   state_d = S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        sum_d   = acc_sum;
        ovf_d   = ovf_q | acc_ovf;
        count_d = count_q + 5'd1;
`ifdef POL_SWEEP_PEAK_EN
        // Strict compares keep the earliest address on ties.
        if (count_q == 5'd0 || cur_tc > max_tc) begin
          pmax_d      = mem_data;
          pmax_addr_d = addr_q;
        end
        if (count_q == 5'd0 || cur_tc < min_tc) begin
          pmin_d      = mem_data;
          pmin_addr_d = addr_q;
        end
`endif
        if (count_d == n_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_WRITE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= 1'b0;
      arg_q   <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef POL_SWEEP_PEAK_EN
      pmax_q      <= '0;
      pmin_q      <= '0;
      pmax_addr_q <= '0;
      pmin_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef POL_SWEEP_PEAK_EN
      pmax_q      <= pmax_d;
      pmin_q      <= pmin_d;
      pmax_addr_q <= pmax_addr_d;
      pmin_addr_q <= pmin_addr_d;
`endif
    end
  end

  // Decoded straight from the state register so reset drops mem_mode and
  // busy asynchronously with no registered lag.
  assign mem_mode = (state_q == S_WRITE);
  assign busy     = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign mem_addr = addr_q;
  assign mem_op   = op_q;
  assign mem_arg  = arg_q;
  assign sum      = sum_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
`ifdef POL_SWEEP_PEAK_EN
  assign peak_max      = pmax_q;
  assign peak_min      = pmin_q;
  assign peak_max_addr = pmax_addr_q;
  assign peak_min_addr = pmin_addr_q;
`endif

endmodule

// File: tb/tb_pol_sweep_acc.sv
// Self-checking bench for pol_sweep_acc: a 13-bit and a 12-bit accumulator
// instance run the same sweeps against their own memory model.
`timescale 1ns/1ps
module tb_pol_sweep_acc;
  import pol_sweep_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       start = 1'b0;
  logic       op_in = 1'b0;
  logic [1:0] arg_in = 2'b00;
  logic [3:0] first_addr = '0, last_addr = '0;
  logic       clr = 1'b1;
  int         pat = 0;

  logic        mode_a, mode_b, op_a, op_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [3:0]  addr_a, addr_b;
  logic [1:0]  arg_a, arg_b;
  logic [8:0]  data_a, data_b;
  logic [12:0] sum_a;
  logic [11:0] sum_b;
  logic [4:0]  count_a, count_b;
  logic [8:0]  mem_a [16];
  logic [8:0]  mem_b [16];
`ifdef POL_SWEEP_PEAK_EN
  logic [8:0] pmax_a, pmin_a, pmax_b, pmin_b;
  logic [3:0] pmax_addr_a, pmin_addr_a, pmax_addr_b, pmin_addr_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pol_sweep_acc #(.ACC_W(13)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .start(start), .op_in(op_in), .arg_in(arg_in),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_mode(mode_a), .mem_addr(addr_a), .mem_op(op_a), .mem_arg(arg_a),
    .mem_data(data_a), .busy(busy_a), .done(done_a), .sum(sum_a),
    .count(count_a), .ovf(ovf_a)
`ifdef POL_SWEEP_PEAK_EN
    , .peak_max(pmax_a), .peak_min(pmin_a),
    .peak_max_addr(pmax_addr_a), .peak_min_addr(pmin_addr_a)
`endif
  );

  pol_sweep_acc #(.ACC_W(12)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .start(start), .op_in(op_in), .arg_in(arg_in),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_mode(mode_b), .mem_addr(addr_b), .mem_op(op_b), .mem_arg(arg_b),
    .mem_data(data_b), .busy(busy_b), .done(done_b), .sum(sum_b),
    .count(count_b), .ovf(ovf_b)
`ifdef POL_SWEEP_PEAK_EN
    , .peak_max(pmax_b), .peak_min(pmin_b),
    .peak_max_addr(pmax_addr_b), .peak_min_addr(pmin_addr_b)
`endif
  );

  // Memory contents per pattern, sign-magnitude.
  function automatic logic [8:0] pat_val(input int p, input logic [3:0] a);
    logic [8:0] t0 [16];
    t0 = '{9'h005, 9'h003, 9'h001, 9'h101, 9'h101, 9'h001, 9'h101, 9'h101,
           9'h103, 9'h103, 9'h105, 9'h003, 9'h103, 9'h001, 9'h101, 9'h101};
    case (p)
      0:       return t0[a];
      1:       return 9'h1FF;
      2:       return {5'b0, a};
      3:       return (a == 4'd5) ? 9'h100 : 9'h007;
      default: return 9'h0FF;
    endcase
  endfunction

  // Memory model: stores only when the DUT writes, so a missing WRITE
  // leaves cleared (zero) data behind.
  always @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (mode_a) mem_a[addr_a] <= pat_val(pat, addr_a);
      if (mode_b) mem_b[addr_b] <= pat_val(pat, addr_b);
    end
  end
  assign data_a = mem_a[addr_a];
  assign data_b = mem_b[addr_b];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] first;
    logic [3:0] last;
    int         pat;
    logic       op;
    logic [1:0] arg;
    int         exp_sum;
    int         exp_cnt;
    int         exp_ovf;
    int         exp_done;
    bit         chk_b;
    int         exp_sum_b;
    int         exp_ovf_b;
  } vec_t;

  vec_t tbl [7];

  // Clears memory, pulses start, then walks the sweep until done.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, writes, seq_bad, fwd_bad, hs_bad;
    bit got_done;
    logic [3:0] ea;
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    pat = v.pat; first_addr = v.first; last_addr = v.last;
    op_in = v.op; arg_in = v.arg; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    op_in = ~v.op; arg_in = ~v.arg;
    cyc = 1; writes = 0; seq_bad = 0; fwd_bad = 0; hs_bad = 0; got_done = 1'b0;
    while (cyc <= 200) begin
      if (mode_a) begin
        ea = v.first + 4'(writes);
        if (addr_a != ea) seq_bad++;
        writes++;
      end
      if (busy_a && (op_a != v.op || arg_a != v.arg)) fwd_bad++;
      if (done_a) begin
        got_done = 1'b1;
        break;
      end
      if (!busy_a) hs_bad++;
      @(posedge CLK); #1;
      cyc++;
    end
    check($sformatf("v%0d done_seen", idx), int'(got_done), 1);
    check($sformatf("v%0d done_cycle", idx), cyc, v.exp_done);
    check($sformatf("v%0d busy_at_done", idx), int'(busy_a), 0);
    check($sformatf("v%0d sum", idx), $signed(sum_a), v.exp_sum);
    check($sformatf("v%0d count", idx), int'(count_a), v.exp_cnt);
    check($sformatf("v%0d ovf", idx), int'(ovf_a), v.exp_ovf);
    check($sformatf("v%0d write_cycles", idx), writes, v.exp_cnt);
    check($sformatf("v%0d addr_seq_errs", idx), seq_bad, 0);
    check($sformatf("v%0d op_arg_errs", idx), fwd_bad, 0);
    check($sformatf("v%0d busy_gaps", idx), hs_bad, 0);
    if (v.chk_b) begin
      check($sformatf("v%0d sum_acc12", idx), $signed(sum_b), v.exp_sum_b);
      check($sformatf("v%0d ovf_acc12", idx), int'(ovf_b), v.exp_ovf_b);
    end
    @(posedge CLK); #1;
    check($sformatf("v%0d done_pulse_width", idx), int'(done_a), 0);
    check($sformatf("v%0d sum_held", idx), $signed(sum_a), v.exp_sum);
  endtask

  task automatic begin_sweep(input logic [3:0] f, input logic [3:0] l, input int p);
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    pat = p; first_addr = f; last_addr = l; op_in = OP_POLY; arg_in = ARG_P1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    //        first  last  pat op        arg     sum    cnt ovf done b  sum_b  ovf_b
    tbl[0] = '{4'd0, 4'd15, 0, OP_POLY,  ARG_P1,    -6, 16, 0, 49, 0,     0, 0};
    tbl[1] = '{4'd0, 4'd15, 1, OP_DERIV, ARG_M1, -4080, 16, 0, 49, 1, -2048, 1};
    tbl[2] = '{4'd0, 4'd15, 4, OP_POLY,  ARG_P2,  4080, 16, 0, 49, 1,  2047, 1};
    tbl[3] = '{4'd14, 4'd1, 2, OP_DERIV, ARG_M2,    30,  4, 0, 13, 0,     0, 0};
    tbl[4] = '{4'd5, 4'd5,  3, OP_POLY,  ARG_M1,     0,  1, 0,  4, 0,     0, 0};
    tbl[5] = '{4'd3, 4'd6,  2, OP_DERIV, ARG_P2,    18,  4, 0, 13, 0,     0, 0};
    tbl[6] = '{4'd8, 4'd10, 0, OP_DERIV, ARG_M2,   -11,  3, 0, 10, 0,     0, 0};

    // Reset values.
    repeat (2) @(posedge CLK);
    #1;
    check("rst mem_mode", int'(mode_a), 0);
    check("rst mem_addr", int'(addr_a), 0);
    check("rst mem_op_arg", int'({op_a, arg_a}), 0);
    check("rst busy_done", int'({busy_a, done_a}), 0);
    check("rst sum", int'(sum_a), 0);
    check("rst count_ovf", int'({count_a, ovf_a}), 0);
    RSTn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
`ifdef POL_SWEEP_PEAK_EN
      if (i == 0) begin
        check("peak_max", int'(pmax_a), 9'h005);
        check("peak_max_addr", int'(pmax_addr_a), 0);
        check("peak_min", int'(pmin_a), 9'h105);
        check("peak_min_addr", int'(pmin_addr_a), 10);
      end
      if (i == 6) begin
        check("peak_max_tie", int'(pmax_a), 9'h103);
        check("peak_max_tie_addr", int'(pmax_addr_a), 8);
      end
`endif
    end

    // start during busy and during DONE is ignored and not queued.
    begin_sweep(4'd0, 4'd1, 2);
    cyc = 1;
    repeat (2) begin
      @(posedge CLK); #1;
      cyc++;
    end
    start = 1'b1;
    while (!done_a && cyc < 50) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("ign done_cycle", cyc, 7);
    check("ign sum", $signed(sum_a), 1);
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ign idle_%0d", k), int'({busy_a, done_a, mode_a}), 0);
      @(posedge CLK); #1;
    end

    // Reset during the WRITE of entry 1: mem_mode must drop at once.
    begin_sweep(4'd0, 4'd15, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("rstw mem_mode_before", int'(mode_a), 1);
    RSTn = 1'b0;
    #1;
    check("rstw mem_mode_after", int'(mode_a), 0);
    check("rstw busy_after", int'(busy_a), 0);
    #2 RSTn = 1'b1;
    @(posedge CLK); #1;

    // Reset during the READ of entry 3 (cycle 11).
    begin_sweep(4'd0, 4'd15, 0);
    repeat (10) @(posedge CLK);
    #1;
    check("rstr busy_before", int'(busy_a), 1);
    check("rstr sum_before", $signed(sum_a), 9);
    check("rstr count_before", int'(count_a), 3);
    RSTn = 1'b0;
    #1;
    check("rstr mem_mode_after", int'(mode_a), 0);
    check("rstr busy_after", int'(busy_a), 0);
    check("rstr sum_after", int'(sum_a), 0);
    check("rstr count_after", int'(count_a), 0);
    check("rstr addr_after", int'(addr_a), 0);
    #2 RSTn = 1'b1;
    @(posedge CLK); #1;
    run_vec(tbl[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a wait outside the bounded loops ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

endmodule

// File: doc/pol_sweep_acc.md
Name: pol_sweep_acc

Overview:
- Downstream sequencer and accumulator for the polynomial memory stage.
- Drives the memory's mode, address, op and arg lines to evaluate and store one result per address over an address range.
- Reads each 9-bit sign-magnitude result back and accumulates a signed two's-complement sum.
- Reports the sum, the entry count and an overflow flag with a start/busy/done handshake.

Parameters:
- ACC_W, 13: accumulator width in two's complement. 13 bits holds 16 x ±255 without overflow.
- DATA_W, 9: memory result width. Bit DATA_W-1 is the sign; the lower bits are the magnitude.

Ports:
- CLK  in  1  clock, all state updates on the rising edge
- RSTn  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- op_in  in  1  0 = polynomial, 1 = derivative
- arg_in  in  2  00 = +1, 01 = +2, 10 = -1, 11 = -2
- first_addr  in  4  first address of the sweep
- last_addr  in  4  last address of the sweep (inclusive)
- mem_mode  out  1  1 = write/evaluate, 0 = read
- mem_addr  out  4  memory address
- mem_op  out  1  op forwarded to memory
- mem_arg  out  2  arg forwarded to memory
- mem_data  in  DATA_W  memory read result (sign-magnitude)
- busy  out  1  high from start acceptance through CAPTURE of the last entry
- done  out  1  one-cycle pulse when the sum is final
- sum  out  ACC_W  accumulated signed sum; held until the next start is accepted
- count  out  5  entries accumulated, 1..16
- ovf  out  1  sticky saturation flag for the current sweep

Behaviour:
- Clock port is CLK; reset is asynchronous, active-low, named RSTn.
- Reset values:
  - State = IDLE.
  - mem_mode = 0 (never write during or on exit from reset).
  - mem_addr = 0, mem_op = 0, mem_arg = 0.
  - busy = 0, done = 0, sum = 0, count = 0, ovf = 0.
- States: IDLE, WRITE, READ, CAPTURE, DONE.
- IDLE:
  - start = 1: latch op_in, arg_in, first_addr and last_addr.
  - Set N = ((last_addr - first_addr) mod 16) + 1.
  - Clear sum, count and ovf; set mem_addr = first_addr; go to WRITE.
  - busy rises in the WRITE cycle.
- WRITE: mem_mode = 1 for exactly one cycle (the memory evaluates and stores on this edge); go to READ.
- READ: mem_mode = 0; go to CAPTURE.
- CAPTURE:
  - mem_mode = 0. At the end of the cycle, convert mem_data to two's complement, add it to sum, and increment count.
  - Negative zero (sign = 1, magnitude = 0) is treated as 0.
  - If count = N: go to DONE.
  - Otherwise: mem_addr = (mem_addr + 1) mod 16 and go to WRITE.
- Address wrap: if last_addr < first_addr, the sweep wraps 15 -> 0. If first_addr = last_addr, N = 1.
- Latency: entry k (0-based) occupies cycles 3k+1 .. 3k+3 after the start edge. DONE is cycle 3N+1.
- DONE: done = 1 and busy = 0 for one cycle; return to IDLE. sum, count and ovf stay stable.
- Arithmetic:
  - Sign-extend the result to ACC_W+1 bits and add.
  - If the result exceeds the ACC_W range, saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf. ovf stays set for the rest of the sweep.
- mem_op and mem_arg stay constant for the whole sweep.
- start while busy or in DONE is ignored. A start pulse seen in DONE is not queued.
- Reset mid-sweep: immediate return to reset values; mem_mode drops to 0 asynchronously.

Optional Feature:
- Macro: POL_SWEEP_PEAK_EN.
- Defined: adds outputs peak_max (DATA_W, sign-magnitude), peak_min (DATA_W, sign-magnitude), peak_max_addr (4) and peak_min_addr (4).
  - They are updated in CAPTURE by signed comparison against the converted value. On a tie, the earliest address is kept.
  - They are initialised from the first captured entry and reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package pol_sweep_pkg holds:
  - the state encoding (3-bit enum);
  - the arg code constants ARG_P1, ARG_P2, ARG_M1, ARG_M2;
  - OP_POLY and OP_DERIV;
  - the default DATA_W;
  - the function sm_to_tc(DATA_W -> ACC_W+1).
- Sub-module pol_sm_acc: combinational sign-magnitude-to-two's-complement conversion plus the saturating adder and overflow detect. The FSM stays in pol_sweep_acc.

Test Plan:
- Memory model returns +5, +3, +1, -1, -1, +1, -1, -1, -3, -3, -5, +3, -3, +1, -1, -1 for addresses 0..15; first = 0, last = 15 -> done at cycle 49, sum = -6, count = 16, ovf = 0.
- Model returns 9'h1FF (-255) everywhere, sweep 0..15, ACC_W = 13 -> sum = -4080, ovf = 0. Same with ACC_W = 12 -> sum = -2048, ovf = 1.
- first = 14, last = 1, model returns mem_data = addr -> mem_addr sequence 14, 15, 0, 1; mem_mode = 1 exactly 4 cycles; sum = 30, count = 4.
- Model returns 9'b100000000 (-0) at address 5, single-entry sweep 5..5 -> sum = 0, count = 1, done pulse at cycle 4.
- RSTn low during the READ of entry 3 -> mem_mode = 0 and busy = 0 immediately; sum = 0; a fresh start after release runs a clean sweep.
- With POL_SWEEP_PEAK_EN defined, first test data -> peak_max = +5 @ addr 0, peak_min = -5 @ addr 10.
